// File: rtl/vdp_vram_arbiter_if.sv
// rtl/vdp_vram_arbiter_if.sv - DMA, host and VRAM macro signals of vdp_vram_arbiter
// host_wait_max is present only when VDP_ARB_WAIT_STATS_EN is defined.
interface vdp_vram_arbiter_if #(
  parameter int ADDR_WIDTH = 13
);
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic                  dma_rd_tick;
  logic [ADDR_WIDTH-1:0] vram_addr;
  logic [7:0]            vram_din;
  logic                  vram_we;
  logic [7:0]            vram_dout;
  logic                  host_addr_load;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic                  host_wr_req;
  logic [7:0]            host_wr_data;
  logic                  host_rd_req;
  logic [7:0]            host_rd_data;
  logic                  host_busy;
  logic                  host_done;
  logic                  host_overrun;
`ifdef VDP_ARB_WAIT_STATS_EN
  logic [7:0]            host_wait_max;
`endif

  modport slave (
    input  dma_addr, dma_rd_tick, vram_dout,
    input  host_addr_load, host_addr, host_wr_req, host_wr_data, host_rd_req,
    output vram_addr, vram_din, vram_we,
    output host_rd_data, host_busy, host_done, host_overrun
`ifdef VDP_ARB_WAIT_STATS_EN
    , output host_wait_max
`endif
  );

  modport master (
    output dma_addr, dma_rd_tick, vram_dout,
    output host_addr_load, host_addr, host_wr_req, host_wr_data, host_rd_req,
    input  vram_addr, vram_din, vram_we,
    input  host_rd_data, host_busy, host_done, host_overrun
`ifdef VDP_ARB_WAIT_STATS_EN
    , input host_wait_max
`endif
  );
endinterface

// File: rtl/vdp_vram_arbiter.sv
// rtl/vdp_vram_arbiter.sv - VRAM arbiter: display DMA priority, one-entry host slot, auto-inc pointer
// Define VDP_ARB_WAIT_STATS_EN to add the host_wait_max stall statistic.
module vdp_vram_arbiter #(
  parameter int VRAM_SIZE       = 8192,
  parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE)
) (
  input logic               pxclk,
  input logic               reset,
  vdp_vram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WR_PEND, RD_PEND, RD_WAIT} state_t;

  localparam logic [VRAM_ADDR_WIDTH-1:0] PTR_LAST = VRAM_ADDR_WIDTH'(VRAM_SIZE - 1);

  state_t                     state;
  logic [VRAM_ADDR_WIDTH-1:0] ptr;
  logic [VRAM_ADDR_WIDTH-1:0] ptr_next;
  logic [7:0]                 wr_byte;
  logic [7:0]                 rd_byte;
  logic                       done;
  logic                       overrun;
  logic                       any_req;
  logic                       retire;

  // Wrap explicitly so non-power-of-two depths also stay in range.
  assign ptr_next = (ptr == PTR_LAST) ? '0 : ptr + VRAM_ADDR_WIDTH'(1);
  assign any_req  = bus.host_wr_req | bus.host_rd_req | bus.host_addr_load;
  assign retire   = (state == WR_PEND && !bus.dma_rd_tick) || state == RD_WAIT;

  // DMA owns the RAM whenever it ticks; the host only sees idle cycles.
  assign bus.vram_addr    = bus.dma_rd_tick ? bus.dma_addr : ptr;
  assign bus.vram_we      = (state == WR_PEND) && !bus.dma_rd_tick;
  assign bus.vram_din     = wr_byte;
  assign bus.host_rd_data = rd_byte;
  assign bus.host_busy    = (state != IDLE);
  assign bus.host_done    = done;
  assign bus.host_overrun = overrun;

  always_ff @(posedge pxclk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      wr_byte <= '0;
      rd_byte <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.host_addr_load)
            ptr <= bus.host_addr;
          if (bus.host_wr_req) begin
            state   <= WR_PEND;
            wr_byte <= bus.host_wr_data;
            overrun <= bus.host_rd_req;
          end else if (bus.host_rd_req) begin
            state <= RD_PEND;
          end
        end
        WR_PEND: begin
          if (!bus.dma_rd_tick) begin
            ptr   <= ptr_next;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        RD_PEND: begin
          if (!bus.dma_rd_tick)
            state <= RD_WAIT;
        end
        RD_WAIT: begin
          rd_byte <= bus.vram_dout;
          ptr     <= ptr_next;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Anything arriving while the slot is full is dropped untouched.
      if (state != IDLE && any_req)
        overrun <= 1'b1;
    end
  end

`ifdef VDP_ARB_WAIT_STATS_EN
  logic [7:0] stall_cnt;
  logic [7:0] wait_max;

  assign bus.host_wait_max = wait_max;

  always_ff @(posedge pxclk) begin
    if (reset) begin
      stall_cnt <= '0;
      wait_max  <= '0;
    end else begin
      if (state == IDLE)
        stall_cnt <= '0;
      else if ((state == WR_PEND || state == RD_PEND) && bus.dma_rd_tick && stall_cnt != 8'hFF)
        stall_cnt <= stall_cnt + 8'd1;
      // Updated at the retiring edge so the value is current alongside host_done.
      if (bus.host_addr_load)
        wait_max <= '0;
      else if (retire && stall_cnt > wait_max)
        wait_max <= stall_cnt;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif
endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// tb/tb_vdp_vram_arbiter.sv - directed bench with transaction-level model for vdp_vram_arbiter
module tb_vdp_vram_arbiter;
  localparam int AW   = 13;
  localparam int SIZE = 8192;
  localparam int OP_NONE = 0, OP_WR = 1, OP_RD = 2;

  logic pxclk = 1'b0;
  logic reset;
  always #5 pxclk = ~pxclk;

  vdp_vram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  vdp_vram_arbiter #(.VRAM_SIZE(SIZE)) dut (.pxclk(pxclk), .reset(reset), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [7:0] pat(input int i);
    logic [31:0] v;
    v = i * 7 + 3;
    return (i == SIZE - 1) ? 8'h3C : v[7:0];
  endfunction

  // Synchronous-read RAM; reset reloads a known pattern.
  logic [7:0] ram [SIZE];
  logic [7:0] ram_q;
  always @(posedge pxclk) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) ram[i] <= pat(i);
    end else if (bus.vram_we) begin
      ram[bus.vram_addr] <= bus.vram_din;
    end
    ram_q <= ram[bus.vram_addr];
  end
  assign bus.vram_dout = ram_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one pending host operation, a byte-array memory and an integer pointer.
  int         m_ptr;
  int         m_op;
  bit         m_issued;
  logic [7:0] m_wdata, m_rd, m_rd_val;
  bit         m_done, m_ovr, model_valid;
  logic [7:0] m_mem [SIZE];

  task automatic model_step();
    bit any;
    if (reset) begin
      m_ptr = 0; m_op = OP_NONE; m_issued = 0; m_rd = 0;
      m_done = 0; m_ovr = 0; model_valid = 1;
      for (int i = 0; i < SIZE; i++) m_mem[i] = pat(i);
    end else begin
      any    = bus.host_wr_req || bus.host_rd_req || bus.host_addr_load;
      m_done = 0;
      m_ovr  = 0;
      if (m_op == OP_NONE) begin
        if (bus.host_addr_load) m_ptr = int'(bus.host_addr);
        if (bus.host_wr_req) begin
          m_op = OP_WR; m_wdata = bus.host_wr_data; m_ovr = bus.host_rd_req;
        end else if (bus.host_rd_req) begin
          m_op = OP_RD; m_issued = 0;
        end
      end else begin
        m_ovr = any;
        if (m_op == OP_WR && !bus.dma_rd_tick) begin
          m_mem[m_ptr] = m_wdata;
          m_ptr  = (m_ptr + 1) % SIZE;
          m_done = 1;
          m_op   = OP_NONE;
        end else if (m_op == OP_RD) begin
          if (m_issued) begin
            m_rd   = m_rd_val;
            m_ptr  = (m_ptr + 1) % SIZE;
            m_done = 1;
            m_op   = OP_NONE;
          end else if (!bus.dma_rd_tick) begin
            m_issued = 1;
            m_rd_val = m_mem[m_ptr];
          end
        end
      end
    end
  endtask

  initial begin
    model_valid = 0;
    forever begin
      @(posedge pxclk);
      model_step();
    end
  end

  initial begin
    logic [31:0] exp_addr;
    bit          exp_we;
    forever begin
      @(negedge pxclk);
      if (model_valid) begin
        exp_addr = bus.dma_rd_tick ? 32'(bus.dma_addr) : 32'(m_ptr);
        exp_we   = (m_op == OP_WR) && !bus.dma_rd_tick;
        chk("vram_addr", 32'(bus.vram_addr), exp_addr);
        chk("vram_we", 32'(bus.vram_we), 32'(exp_we));
        if (exp_we) chk("vram_din", 32'(bus.vram_din), 32'(m_wdata));
        chk("host_busy", 32'(bus.host_busy), 32'(m_op != OP_NONE));
        chk("host_done", 32'(bus.host_done), 32'(m_done));
        chk("host_overrun", 32'(bus.host_overrun), 32'(m_ovr));
        chk("host_rd_data", 32'(bus.host_rd_data), 32'(m_rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pxclk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.dma_addr = '0; bus.dma_rd_tick = 1'b0;
    bus.host_addr_load = 1'b0; bus.host_addr = '0;
    bus.host_wr_req = 1'b0; bus.host_wr_data = '0; bus.host_rd_req = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", 32'(bus.host_busy), 0);
    chk("rst_done", 32'(bus.host_done), 0);
    chk("rst_ovr", 32'(bus.host_overrun), 0);
    chk("rst_rd_data", 32'(bus.host_rd_data), 0);
    chk("rst_we", 32'(bus.vram_we), 0);
    chk("rst_ptr", 32'(bus.vram_addr), 0);

    // Load and write with idle DMA.
    bus.host_addr = 13'h0100; bus.host_addr_load = 1'b1; tick(); bus.host_addr_load = 1'b0;
    chk("t1_ptr", 32'(bus.vram_addr), 32'h100);
    bus.host_wr_data = 8'hA5; bus.host_wr_req = 1'b1; tick(); bus.host_wr_req = 1'b0;
    chk("t1_we", 32'(bus.vram_we), 1);
    chk("t1_addr", 32'(bus.vram_addr), 32'h100);
    chk("t1_din", 32'(bus.vram_din), 32'hA5);
    chk("t1_done_early", 32'(bus.host_done), 0);
    tick();
    chk("t1_done", 32'(bus.host_done), 1);
    chk("t1_ptr_inc", 32'(bus.vram_addr), 32'h101);
    chk("t1_ram", 32'(ram[13'h100]), 32'hA5);

    // Write stalled by five DMA cycles.
    bus.host_wr_data = 8'h5A; bus.host_wr_req = 1'b1; tick(); bus.host_wr_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.dma_rd_tick = 1'b1; bus.dma_addr = 13'(13'h0800 + i); #1;
      chk("t2_dma_addr", 32'(bus.vram_addr), 32'(13'h0800 + i));
      chk("t2_we_stall", 32'(bus.vram_we), 0);
      tick();
    end
    bus.dma_rd_tick = 1'b0; #1;
    chk("t2_we", 32'(bus.vram_we), 1);
    chk("t2_addr", 32'(bus.vram_addr), 32'h101);
    tick();
    chk("t2_done", 32'(bus.host_done), 1);
    chk("t2_ram", 32'(ram[13'h101]), 32'h5A);

    // Read at the top address, pointer wraps.
    bus.host_addr = 13'h1FFF; bus.host_addr_load = 1'b1; tick(); bus.host_addr_load = 1'b0;
    bus.host_rd_req = 1'b1; tick(); bus.host_rd_req = 1'b0;
    chk("t3_busy", 32'(bus.host_busy), 1);
    tick();
    chk("t3_done_early", 32'(bus.host_done), 0);
    tick();
    chk("t3_done", 32'(bus.host_done), 1);
    chk("t3_data", 32'(bus.host_rd_data), 32'h3C);
    chk("t3_wrap", 32'(bus.vram_addr), 0);
    tick();
    chk("t3_hold", 32'(bus.host_rd_data), 32'h3C);

    // Simultaneous write+read, then a request while busy.
    bus.host_wr_data = 8'h77; bus.host_wr_req = 1'b1; bus.host_rd_req = 1'b1; tick();
    bus.host_wr_req = 1'b0; bus.host_rd_req = 1'b0;
    chk("t4_ovr1", 32'(bus.host_overrun), 1);
    bus.host_rd_req = 1'b1; tick(); bus.host_rd_req = 1'b0;
    chk("t4_ovr2", 32'(bus.host_overrun), 1);
    chk("t4_done", 32'(bus.host_done), 1);
    tick();
    chk("t4_ovr_clr", 32'(bus.host_overrun), 0);
    chk("t4_ptr_once", 32'(bus.vram_addr), 1);
    chk("t4_ram", 32'(ram[0]), 32'h77);

    // Load while a stalled write is pending is dropped.
    bus.host_wr_data = 8'h11; bus.host_wr_req = 1'b1; tick(); bus.host_wr_req = 1'b0;
    bus.dma_rd_tick = 1'b1; bus.dma_addr = 13'h0040;
    bus.host_addr = 13'h0555; bus.host_addr_load = 1'b1; tick(); bus.host_addr_load = 1'b0;
    chk("t4b_ovr", 32'(bus.host_overrun), 1);
    bus.dma_rd_tick = 1'b0; #1;
    chk("t4b_addr", 32'(bus.vram_addr), 1);
    tick();
    chk("t4b_ptr", 32'(bus.vram_addr), 2);
    chk("t4b_ram", 32'(ram[1]), 32'h11);

    // Load and read together: read uses the new pointer.
    bus.host_addr = 13'h0300; bus.host_addr_load = 1'b1; bus.host_rd_req = 1'b1; tick();
    bus.host_addr_load = 1'b0; bus.host_rd_req = 1'b0;
    chk("t5_addr", 32'(bus.vram_addr), 32'h300);
    tick(); tick();
    chk("t5_done", 32'(bus.host_done), 1);
    chk("t5_data", 32'(bus.host_rd_data), 32'h03);
    chk("t5_ptr", 32'(bus.vram_addr), 32'h301);

    // Reset during a DMA-stalled read.
    bus.host_rd_req = 1'b1; tick(); bus.host_rd_req = 1'b0;
    bus.dma_rd_tick = 1'b1; bus.dma_addr = 13'h0020;
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0; bus.dma_rd_tick = 1'b0; #1;
    chk("t6_busy", 32'(bus.host_busy), 0);
    chk("t6_done", 32'(bus.host_done), 0);
    chk("t6_we", 32'(bus.vram_we), 0);
    chk("t6_ptr", 32'(bus.vram_addr), 0);
    tick();
    chk("t6_done2", 32'(bus.host_done), 0);
    chk("t6_rd_data", 32'(bus.host_rd_data), 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vdp_vram_arbiter.md
Name: vdp_vram_arbiter

Overview:
Shares the single-port VDP VRAM between two requesters. Requester one is the display pipeline's DMA read stream, which already merges the gfx and sprite FSMs. Requester two is the host (Z8S180) data port. Display DMA has absolute priority and zero added latency. Host reads and writes are held in a one-entry pending slot and retire in the first cycle DMA leaves the RAM idle. The block also owns the auto-incrementing host VRAM address pointer, and sits between the VDP FSM, the CPU register interface and the VRAM macro.

Parameters:
VRAM_SIZE, 8192, VRAM depth in bytes.
VRAM_ADDR_WIDTH, $clog2(VRAM_SIZE), address width.

Ports:
pxclk  in  1  pixel clock (25 MHz domain, doubled pipeline)
reset  in  1  synchronous, active-high
dma_addr  in  VRAM_ADDR_WIDTH  display DMA address
dma_rd_tick  in  1  display DMA read this cycle
vram_addr  out  VRAM_ADDR_WIDTH  RAM address
vram_din  out  8  RAM write data
vram_we  out  1  RAM write enable
vram_dout  in  8  RAM read data; valid one cycle after its address
host_addr_load  in  1  load pointer from host_addr (one-cycle pulse)
host_addr  in  VRAM_ADDR_WIDTH  new pointer value
host_wr_req  in  1  write request pulse
host_wr_data  in  8  write byte, sampled with host_wr_req
host_rd_req  in  1  read request pulse
host_rd_data  out  8  last read byte
host_busy  out  1  request pending
host_done  out  1  one-cycle pulse when a request retires
host_overrun  out  1  one-cycle pulse when a request or load is dropped

Behaviour:
- Reset (synchronous, active-high): pointer=0, state=IDLE, host_rd_data=0, host_done=0, host_overrun=0, host_busy=0, vram_we=0.
- Reset mid-operation aborts any pending request with no RAM write, no host_done and no pointer change.
- vram_addr is combinational: dma_rd_tick ? dma_addr : pointer.
- vram_we is combinational: (state==WR_PEND && !dma_rd_tick).
- vram_din = registered write byte.
- A DMA cycle is never delayed or modified.
- States:
  - IDLE: host_wr_req -> WR_PEND, latch host_wr_data. host_rd_req -> RD_PEND. host_addr_load -> pointer=host_addr, stay in IDLE.
  - WR_PEND: stalls while dma_rd_tick=1. At the first edge with dma_rd_tick=0: RAM written, pointer+1, host_done=1 next cycle, -> IDLE.
  - RD_PEND: stalls while dma_rd_tick=1. At the first edge with dma_rd_tick=0: address sampled by RAM, -> RD_WAIT.
  - RD_WAIT: unconditional. Capture vram_dout into host_rd_data, pointer+1, host_done=1, -> IDLE. DMA may use the RAM during this cycle.
- host_busy = (state!=IDLE).
- Minimum latency from the request cycle: write done asserted 2 cycles later; read done and data valid 3 cycles later. Every DMA stall cycle adds exactly 1.
- Pointer increment wraps modulo VRAM_SIZE: 0x1FFF+1=0x0000 at the default size.
- Simultaneous events in IDLE:
  - wr_req+rd_req: write wins, read dropped, host_overrun pulses.
  - load+req: load takes effect first, and the request uses the new pointer.
- Any req or load while host_busy=1 is dropped and host_overrun pulses. Pending data, pointer and state are unaffected.
- host_rd_data holds its value until the next read retires.

Optional Feature:
VDP_ARB_WAIT_STATS_EN
- Defined: adds output host_wait_max[7:0], the saturating maximum over all requests of stall cycles spent in WR_PEND/RD_PEND. It saturates at 255, is cleared by reset and by host_addr_load, and updates on host_done.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Load pointer 0x0100, write 0xA5 with dma_rd_tick=0 -> vram_we=1 @addr 0x0100 one cycle later; host_done 2 cycles after req; pointer=0x0101.
- Hold dma_rd_tick=1 for 5 cycles after a write req -> vram_addr follows dma_addr, vram_we=0 throughout; write commits on cycle 6; host_done on cycle 7 (with the feature enabled, host_wait_max=5).
- Preload RAM[0x1FFF]=0x3C, load 0x1FFF, read -> host_rd_data=0x3C 3 cycles after req; pointer wraps to 0x0000.
- Assert wr_req+rd_req in IDLE -> single write performed, host_overrun=1 for one cycle; a second req while busy -> dropped, another overrun pulse, pointer advances only once.
- Assert reset during RD_PEND with DMA stalling -> no host_done, pointer=0, host_busy=0 next cycle, vram_we stays 0.
